// File: rtl/simon_pkg.sv
// Shared types, default timing constants and the speed-code to period mapping
// used by the pacing timer, the game FSM timeout logic and the bench.
package simon_pkg;

  typedef logic [2:0]  speed_t;
  typedef logic [15:0] period_t;

  localparam int BASE_MS = 800;
  localparam int STEP_MS = 100;
  localparam int MIN_MS  = 100;

  typedef enum logic {
    FT_IDLE = 1'b0,
    FT_RUN  = 1'b1
  } ft_state_e;

  // period = max(base - speed*step, min), computed without underflow
  function automatic period_t speed_to_period(
    input speed_t  speed,
    input period_t base_ms = period_t'(BASE_MS),
    input period_t step_ms = period_t'(STEP_MS),
    input period_t min_ms  = period_t'(MIN_MS)
  );
    logic [18:0] prod;
    logic [18:0] room;
    prod = 19'(speed) * 19'(step_ms);
    if (base_ms <= min_ms) begin
      return min_ms;
    end
    room = 19'(base_ms - min_ms);
    if (prod >= room) begin
      return min_ms;
    end
    return base_ms - prod[15:0];
  endfunction

endpackage

// File: rtl/flash_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE enabled clocks.
// The count is held at zero whenever the enable is low or clear is high.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en & (cnt_q == LAST);

  // next count: wrap on tick, zero while idle or cleared
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_timer.sv
// Pacing timer for the game FSM: strobes pulse once per speed-dependent
// period and provides a 50 % flash phase for LED gating during playback.
//
// state | meaning
// IDLE  | counters held at zero, all outputs low
// RUN   | ms counter advancing on ticks, pulse at end of each period
module flash_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int BASE_MS = simon_pkg::BASE_MS,
  parameter int STEP_MS = simon_pkg::STEP_MS,
  parameter int MIN_MS  = simon_pkg::MIN_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_speed,
  input  logic [2:0] speed,
  input  logic       halt,
  output logic       pulse,
  output logic       flash_on,
  output logic       running
);

  import simon_pkg::*;

  localparam int PRESCALE = CLK_HZ / TICK_HZ;

  ft_state_e state_q, state_d;
  period_t   period_q, period_d;
  period_t   ms_q, ms_d;
  logic      flash_on_q, flash_on_d;
  logic      pulse_raw;
  logic      tick;
  logic      tick_clr;
  logic      tick_en;
  logic      terminal;

  assign tick_en  = (state_q == FT_RUN);
  assign terminal = tick && (ms_q == (period_q - 16'd1));

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .tick(tick)
  );

  // next state, period latch, ms counter and pulse decode
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    ms_d      = ms_q;
    pulse_raw = 1'b0;
    tick_clr  = 1'b0;
    case (state_q)
      FT_IDLE: begin
        ms_d = '0;
        if (load_speed) begin
          period_d = speed_to_period(speed, period_t'(BASE_MS),
                                     period_t'(STEP_MS), period_t'(MIN_MS));
          tick_clr = 1'b1;
          state_d  = FT_RUN;
        end
      end
      FT_RUN: begin
        if (halt) begin
          ms_d     = '0;
          tick_clr = 1'b1;
          state_d  = FT_IDLE;
        end else if (load_speed) begin
          // restart suppresses any pulse due this cycle
          period_d = speed_to_period(speed, period_t'(BASE_MS),
                                     period_t'(STEP_MS), period_t'(MIN_MS));
          ms_d     = '0;
          tick_clr = 1'b1;
        end else if (terminal) begin
          pulse_raw = 1'b1;
          ms_d      = '0;
        end else if (tick) begin
          ms_d = ms_q + 16'd1;
        end
      end
      default: begin
        state_d = FT_IDLE;
        ms_d    = '0;
      end
    endcase
    flash_on_d = (state_d == FT_RUN) && (ms_d < (period_d >> 1));
  end

  // state, period, ms and flash phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FT_IDLE;
      period_q   <= period_t'(BASE_MS);
      ms_q       <= '0;
      flash_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      ms_q       <= ms_d;
      flash_on_q <= flash_on_d;
    end
  end

  assign pulse    = pulse_raw & ~rst;
  assign flash_on = flash_on_q;
  assign running  = (state_q == FT_RUN);

endmodule

// File: doc/flash_timer.md
Name: flash_timer

Overview:
- Pacing timer that sits directly upstream of the game FSM.
- Takes the FSM's `load_speed` command and 3-bit `speed` code and produces the one-cycle `pulse` the FSM uses to step through sequence playback and player-turn timeouts.
- Also produces a 50 % duty `flash_on` phase that the FSM forwards as `flash_clk` to gate the LEDs during playback.
- Connects through the `flash_timer` modport of the FSM signal interface; `flash_on`, `halt` and `running` are extra side-band ports.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, internal time-base tick rate in Hz (1 ms default).
- BASE_MS, 800, period in ticks for speed code 0.
- STEP_MS, 100, period reduction per speed increment.
- MIN_MS, 100, floor on period in ticks.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- fsm.load_speed  input  1  latch `speed`, restart timing.
- fsm.speed  input  3  speed code, 0 slowest, 7 fastest.
- halt  input  1  stop timing, return to IDLE.
- fsm.pulse  output  1  one-cycle strobe at end of each period.
- flash_on  output  1  high during first half of each period.
- running  output  1  high in RUN state.

Behaviour:
- One clock (`clk`); reset `rst` is synchronous and active-high. All state updates on rising `clk`.
- Reset values: `pulse`=0, `flash_on`=0, `running`=0, state=IDLE, prescaler=0, tick counter=0, period register=BASE_MS.
- Period arithmetic:
  - `period` = max(BASE_MS − speed·STEP_MS, MIN_MS), computed in 16-bit unsigned with no underflow: if speed·STEP_MS ≥ BASE_MS − MIN_MS, result is MIN_MS.
  - Defaults give 800, 700, …, 100 for codes 0..7.
  - `half` = period >> 1.
- Prescaler:
  - PRESCALE = CLK_HZ / TICK_HZ (integer, elaborated at compile time).
  - Counts 0..PRESCALE−1 in RUN only; `tick` = 1 for one cycle when count == PRESCALE−1, then wraps to 0.
  - Held at 0 in IDLE.
- State machine, two states:
  - IDLE: counters held at 0, outputs 0.
    - `load_speed`=1 → latch period from `speed`, clear counters, go to RUN next cycle.
  - RUN: tick counter `ms` advances by 1 on each `tick`.
    - When `tick` and `ms` == period−1: `pulse`=1 for exactly that cycle, `ms` → 0.
    - `flash_on` = (ms < half), registered; equals 1 on the first RUN cycle.
    - `halt`=1 → IDLE next cycle, outputs 0.
    - `load_speed`=1 → re-latch period, clear prescaler and `ms`, stay in RUN (restart).
- First pulse latency after `load_speed` at cycle N: pulse at cycle N + 1 + period·PRESCALE − 1, i.e. exactly period·PRESCALE cycles after the latch edge. All subsequent pulses are period·PRESCALE apart.
- Priority: `rst` > `halt` > `load_speed` > terminal tick.
  - `load_speed` coinciding with a terminal tick suppresses that pulse.
  - `halt` and `load_speed` together → IDLE.
- `speed` is sampled only on `load_speed`; changes at other times are ignored.
- `pulse` is never asserted in IDLE or on the cycle reset deasserts.
- Reset mid-period: everything returns to reset values next cycle; no residual pulse.

Decomposition:
- Shared package `simon_pkg` holds:
  - `speed_t` (logic [2:0]).
  - `period_t` (logic [15:0]).
  - Default constants BASE_MS, STEP_MS, MIN_MS.
  - Function `speed_to_period(speed_t)` returning `period_t`, reused by the FSM's timeout logic and the bench.
- One sub-module `tick_gen` (parameterised prescaler with enable and synchronous clear, outputs `tick`).
- The state machine and period counter stay in `flash_timer`.

Test Plan:
Bench runs with CLK_HZ=1000, TICK_HZ=100 (PRESCALE=10).
- Reset then `load_speed` with speed=0 at cycle 0 → `running`=1 at cycle 1; `pulse` at cycles 8000, 16000, 24000; `flash_on` high cycles 1..4000, low 4001..8000.
- speed=7 → period 100 ticks; `pulse` every 1000 cycles; `flash_on` toggles every 500 cycles.
- BASE_MS=300, STEP_MS=100, MIN_MS=100, speed=5 → period clamps to 100, no underflow; `pulse` every 1000 cycles.
- In RUN at speed=0, assert `load_speed` with speed=3 on the terminal-tick cycle → no pulse that cycle; next pulse 5000 cycles later.
- `halt` mid-period → `running`, `flash_on`, `pulse` all 0 next cycle and remain 0 for 20000 cycles; a later `load_speed` restarts with full-period latency.
- Assert `rst` 3 cycles before a due pulse → no pulse; outputs 0; `speed` changes without `load_speed` have no effect on period.
